// File: rtl/mux_scan_if.sv
// Bus bundle for mux_scan: channel inputs, select/mode/enable controls and the
// registered output word with its valid/ready handshake.
interface mux_scan_if #(
    parameter int WIDTH = 1,
    parameter int CH    = 8
);
    localparam int SW = $clog2(CH);

    logic [CH*WIDTH-1:0] I;
    logic [SW-1:0]       S;
    logic                mode;
    logic                en;
    logic [WIDTH-1:0]    O;
    logic [SW-1:0]       o_sel;
    logic                o_valid;
    logic                o_ready;
    logic                wrap;

    modport master (
        output I, S, mode, en, o_ready,
        input  O, o_sel, o_valid, wrap
    );

    modport slave (
        input  I, S, mode, en, o_ready,
        output O, o_sel, o_valid, wrap
    );
endinterface

// File: rtl/mux_scan.sv
// Registered channel multiplexer with manual select or round-robin auto-scan,
// a one-word output buffer under valid/ready flow control and a pass-end pulse.
module mux_scan #(
    parameter int WIDTH = 1,
    parameter int CH    = 8
) (
    input  logic     clk,
    input  logic     rstn,
    mux_scan_if.slave bus
);
    localparam int SW = $clog2(CH);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] ch_w [CH];
    logic [SW-1:0]    csel;
    logic             cap;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            assign ch_w[gi] = bus.I[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign csel = bus.mode ? ptr_q : bus.S;
    // A held word may be replaced in the same edge it is consumed.
    assign cap  = bus.en & ((state_q == EMPTY) | bus.o_ready);

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        wrap_d  = 1'b0;
        if (cap) begin
            state_d = FULL;
            o_d     = ch_w[csel];
            sel_d   = csel;
            ptr_d   = csel + SW'(1);
            wrap_d  = bus.mode & (csel == SW'(CH - 1));
        end else if (state_q == FULL && bus.o_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
            o_q     <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.O       = o_q;
    assign bus.o_sel   = sel_q;
    assign bus.o_valid = (state_q == FULL);
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: a 1-bit/8-channel and an 8-bit/4-channel instance.
module tb_mux_scan;
    logic clk;
    logic rstn;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] o;
        logic [2:0] sel;
        logic       wrap;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];

    mux_scan_if #(.WIDTH(1), .CH(8)) if1 ();
    mux_scan_if #(.WIDTH(8), .CH(4)) if8 ();

    mux_scan #(.WIDTH(1), .CH(8)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
    mux_scan #(.WIDTH(8), .CH(4)) dut8 (.clk(clk), .rstn(rstn), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [7:0] o, input logic [2:0] sel, input logic w);
        exp_t e;
        e.o = o; e.sel = sel; e.wrap = w;
        return e;
    endfunction

    // Monitors: a word is new when the previous sample showed empty or a consumer accept.
    logic fresh1 = 1'b1;
    exp_t held1;
    always @(negedge clk) begin
        if (!rstn) begin
            fresh1 = 1'b1;
        end else begin
            if (if1.o_valid) begin
                if (fresh1) begin
                    if (q1.size() == 0) begin
                        chk("d1_unexpected_word", 32'(if1.O), 32'hFFFF_FFFF);
                    end else begin
                        held1 = q1.pop_front();
                        chk("d1_O", 32'(if1.O), 32'(held1.o));
                        chk("d1_sel", 32'(if1.o_sel), 32'(held1.sel));
                        chk("d1_wrap", 32'(if1.wrap), 32'(held1.wrap));
                    end
                end else begin
                    chk("d1_hold_O", 32'(if1.O), 32'(held1.o));
                    chk("d1_hold_wrap", 32'(if1.wrap), 32'h0);
                end
            end
            fresh1 = !if1.o_valid || if1.o_ready;
        end
    end

    logic fresh8 = 1'b1;
    exp_t held8;
    always @(negedge clk) begin
        if (!rstn) begin
            fresh8 = 1'b1;
        end else begin
            if (if8.o_valid) begin
                if (fresh8) begin
                    if (q8.size() == 0) begin
                        chk("d8_unexpected_word", 32'(if8.O), 32'hFFFF_FFFF);
                    end else begin
                        held8 = q8.pop_front();
                        chk("d8_O", 32'(if8.O), 32'(held8.o));
                        chk("d8_sel", 32'(if8.o_sel), 32'(held8.sel));
                        chk("d8_wrap", 32'(if8.wrap), 32'(held8.wrap));
                    end
                end else begin
                    chk("d8_hold_O", 32'(if8.O), 32'(held8.o));
                    chk("d8_hold_sel", 32'(if8.o_sel), 32'(held8.sel));
                    chk("d8_hold_wrap", 32'(if8.wrap), 32'h0);
                end
            end
            fresh8 = !if8.o_valid || if8.o_ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        if1.I = '0; if1.S = '0; if1.mode = 1'b0; if1.en = 1'b0; if1.o_ready = 1'b0;
        if8.I = '0; if8.S = '0; if8.mode = 1'b0; if8.en = 1'b0; if8.o_ready = 1'b0;
        #2;
        chk("rst_d1_valid", 32'(if1.o_valid), 32'h0);
        chk("rst_d1_O", 32'(if1.O), 32'h0);
        chk("rst_d8_O", 32'(if8.O), 32'h0);
        chk("rst_d8_sel", 32'(if8.o_sel), 32'h0);
        chk("rst_d8_valid", 32'(if8.o_valid), 32'h0);
        chk("rst_d8_wrap", 32'(if8.wrap), 32'h0);
        tick();
        rstn = 1'b1;

        // Manual sweep on the 1-bit instance: zero then one-hot for each select.
        if1.mode = 1'b0; if1.en = 1'b1; if1.o_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            if1.S = 3'(s);
            if1.I = 8'h00;
            q1.push_back(mk(8'h00, 3'(s), 1'b0));
            tick();
            if1.I = 8'h01 << s;
            q1.push_back(mk(8'h01, 3'(s), 1'b0));
            tick();
        end
        if1.en = 1'b0;
        tick();
        tick();
        chk("d1_drained_valid", 32'(if1.o_valid), 32'h0);

        // Auto-scan pass on the 8-bit instance.
        if8.I = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        if8.mode = 1'b1; if8.en = 1'b1; if8.o_ready = 1'b1;
        q8.push_back(mk(8'hA0, 3'd0, 1'b0)); tick();
        q8.push_back(mk(8'hA1, 3'd1, 1'b0)); tick();
        q8.push_back(mk(8'hA2, 3'd2, 1'b0)); tick();
        q8.push_back(mk(8'hA3, 3'd3, 1'b1)); tick();
        q8.push_back(mk(8'hA0, 3'd0, 1'b0)); tick();
        q8.push_back(mk(8'hA1, 3'd1, 1'b0)); tick();

        // Backpressure while A1 is held; channel 1 changes underneath.
        if8.o_ready = 1'b0;
        if8.I[15:8] = 8'h55;
        tick(); tick(); tick();
        chk("bp_valid", 32'(if8.o_valid), 32'h1);
        chk("bp_O", 32'(if8.O), 32'hA1);
        if8.I[15:8] = 8'hA1;
        if8.o_ready = 1'b1;
        q8.push_back(mk(8'hA2, 3'd2, 1'b0)); tick();

        // Drain while A2 is held.
        if8.en = 1'b0;
        tick();
        chk("drain_valid", 32'(if8.o_valid), 32'h0);
        chk("drain_O", 32'(if8.O), 32'hA2);

        // Manual capture of channel 2, then auto continues from 3.
        if8.mode = 1'b0; if8.S = 2'd2; if8.en = 1'b1;
        q8.push_back(mk(8'hA2, 3'd2, 1'b0)); tick();
        if8.mode = 1'b1;
        q8.push_back(mk(8'hA3, 3'd3, 1'b1)); tick();
        q8.push_back(mk(8'hA0, 3'd0, 1'b0)); tick();
        q8.push_back(mk(8'hA1, 3'd1, 1'b0)); tick();
        if8.o_ready = 1'b0;
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_rst_O", 32'(if8.O), 32'h0);
        chk("async_rst_valid", 32'(if8.o_valid), 32'h0);
        chk("async_rst_sel", 32'(if8.o_sel), 32'h0);
        tick();
        rstn = 1'b1;
        if8.o_ready = 1'b1;
        q8.push_back(mk(8'hA0, 3'd0, 1'b0)); tick();
        q8.push_back(mk(8'hA1, 3'd1, 1'b0)); tick();
        if8.en = 1'b0;
        tick();
        tick();

        chk("q1_empty", 32'(q1.size()), 32'h0);
        chk("q8_empty", 32'(q8.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each channel and of O.
REQ-002 Parameter CH, default 8: channel count, power of two, >= 2.
REQ-003 Local parameter SW = log2(CH): select width, default 3.
REQ-004 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 I  input  CH*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 S  input  SW  manual channel select.
REQ-009 mode  input  1  0 = manual (use S), 1 = auto-scan (use internal pointer).
REQ-010 en  input  1  sample request.
REQ-011 O  output  WIDTH  registered selected data.
REQ-012 o_sel  output  SW  channel index that produced O.
REQ-013 o_valid  output  1  O/o_sel hold an unconsumed word.
REQ-014 o_ready  input  1  consumer accepts the word when o_valid & o_ready.
REQ-015 wrap  output  1  one-cycle pulse marking the end of an auto-scan pass.

Function
REQ-016 Two states shall exist: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-017 Capture condition: cap = en & (!o_valid | o_ready), giving full throughput back-to-back.
REQ-018 Selected channel: csel = S if mode=0, else ptr.
REQ-019 On cap, at the next rising edge: O <= channel csel of I, o_sel <= csel, o_valid <= 1. Latency is 1 cycle.
REQ-020 I, S and mode shall be sampled only at a capture edge.
REQ-021 In FULL with o_ready=0, O, o_sel and o_valid shall stay stable regardless of I, S, en and mode.
REQ-022 In FULL with o_ready=1 and en=0: o_valid <= 0 and the state returns to EMPTY. O and o_sel retain their last values.
REQ-023 In EMPTY with en=0, the state shall not change. o_ready is ignored while EMPTY.
REQ-024 Pointer ptr (SW bits) on each cap:
- auto mode: ptr <= (ptr+1) mod CH, wrapping from CH-1 to 0;
- manual mode: ptr <= (S+1) mod CH, so a later switch to auto continues after the last manual channel.
REQ-025 ptr shall not change without cap.
REQ-026 wrap shall be registered alongside O. It is high for exactly one cycle: the first cycle O shows an auto-mode capture of channel CH-1.
REQ-027 wrap shall stay low during backpressure after that first cycle, and in manual mode.
REQ-028 A mode change takes effect at the next cap only; a word already held is unaffected.

Reset
REQ-029 While rstn=0, asynchronously and without a clock edge:
- O=0, o_sel=0, o_valid=0, wrap=0;
- ptr=0, state EMPTY.
REQ-030 Reset during FULL shall discard the held word; no handshake completes for it.
REQ-031 The first capture shall be possible on the first rising edge with rstn=1 and en=1.

Verification
REQ-032 WIDTH=1, CH=8, manual, en=1, o_ready=1. For each S=0..7, apply I=0 then I=one-hot(S) -> O=0 then O=1, each one cycle later, with o_sel=S.
REQ-033 WIDTH=8, CH=4, auto, channels 8'hA0..8'hA3, en=1, o_ready=1 -> O sequence A0,A1,A2,A3,A0. wrap=1 only in the A3 cycle.
REQ-034 Backpressure. Held O=A1, o_ready=0 for 3 cycles, channel 1 changed to 8'h55 -> O stays A1, o_valid=1, ptr unchanged. Then o_ready=1 -> next O=A2.
REQ-035 Mode switch. Manual capture with S=2, then mode=1 -> subsequent o_sel = 3, 0; wrap pulses with o_sel=3.
REQ-036 Reset mid-operation. rstn=0 between clock edges while o_valid=1 -> O=0, o_valid=0 immediately. After release in auto mode, first o_sel=0.
REQ-037 Drain. en=0, o_ready=1 while FULL with O=A2 -> o_valid=0 after one edge, O stays A2.
